// File: rtl/axil_gpio_regs_if.sv
// AXI-Lite bus bundle shared by the GPIO register block and its master.
// Slave modport is what the register block sees; Master is the mirror.
interface AXIL_IF #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport Slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

    modport Master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );
endinterface

// File: rtl/axil_gpio_regs.sv
// AXI-Lite register block for board GPIO: ID, synchronised switch/button
// inputs, LED drive, sticky button rising-edge flags (W1C) and a scratch word.
// Write and read channels are independent; AW and W may arrive in any order.
module axil_gpio_regs #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] ID_VALUE   = 32'h4750_494F
) (
    input  logic        clk,
    input  logic        reset,
    AXIL_IF.Slave       axil_if,
    input  logic [3:0]  sw,
    input  logic [3:0]  btn,
    output logic [15:0] led
);

    localparam int STRB_W = DATA_WIDTH / 8;

    localparam logic [2:0] REG_ID      = 3'd0;
    localparam logic [2:0] REG_INPUTS  = 3'd1;
    localparam logic [2:0] REG_LED     = 3'd2;
    localparam logic [2:0] REG_EDGE    = 3'd3;
    localparam logic [2:0] REG_SCRATCH = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // ------------------------------------------------------------------
    // Input synchronisers and button edge detect
    // ------------------------------------------------------------------
    logic [3:0] sw_meta_q, sw_s_q;
    logic [3:0] btn_meta_q, btn_s_q, btn_prev_q;
    logic [3:0] btn_rise;

    // Two-flop synchronisers plus a prev stage on the buttons for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta_q  <= '0;
            sw_s_q     <= '0;
            btn_meta_q <= '0;
            btn_s_q    <= '0;
            btn_prev_q <= '0;
        end else begin
            sw_meta_q  <= sw;
            sw_s_q     <= sw_meta_q;
            btn_meta_q <= btn;
            btn_s_q    <= btn_meta_q;
            btn_prev_q <= btn_s_q;
        end
    end

    assign btn_rise = btn_s_q & ~btn_prev_q;

    // ------------------------------------------------------------------
    // Write channel: one-entry holding registers for AW and W
    // ------------------------------------------------------------------
    logic                    aw_held_q, aw_held_d;
    logic [2:0]              aw_idx_q, aw_idx_d;
    logic                    w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
    logic [STRB_W-1:0]       w_strb_q, w_strb_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;

    logic                    awready_w, wready_w;
    logic                    aw_hs, w_hs, wr_fire;
    logic [2:0]              wr_idx;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [STRB_W-1:0]       wr_strb;
    logic [ADDR_WIDTH-1:0]   awaddr_w, araddr_w;

    assign awaddr_w  = axil_if.awaddr;
    assign araddr_w  = axil_if.araddr;

    assign awready_w = !aw_held_q && !bvalid_q;
    assign wready_w  = !w_held_q && !bvalid_q;
    assign aw_hs     = axil_if.awvalid && awready_w;
    assign w_hs      = axil_if.wvalid && wready_w;

    // A held beat takes priority; otherwise use the beat handshaking now.
    assign wr_idx  = aw_held_q ? aw_idx_q : awaddr_w[4:2];
    assign wr_data = w_held_q  ? w_data_q : axil_if.wdata;
    assign wr_strb = w_held_q  ? w_strb_q : axil_if.wstrb;
    assign wr_fire = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;

    // Holding-register and B-channel next state
    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (wr_fire) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (wr_idx > REG_SCRATCH) ? RESP_SLVERR : RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                aw_idx_d  = awaddr_w[4:2];
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                w_data_d = axil_if.wdata;
                w_strb_d = axil_if.wstrb;
            end
            if (bvalid_q && axil_if.bready) begin
                bvalid_d = 1'b0;
            end
        end
    end

    // Write-channel state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [15:0]           led_q, led_d;
    logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
    logic [3:0]            edge_q, edge_d;
    logic [3:0]            edge_clr;

    // Byte-strobed updates for LED/SCRATCH; edge flags clear on W1C but a
    // coincident new rising edge keeps its bit set.
    always_comb begin
        led_d     = led_q;
        scratch_d = scratch_q;
        edge_clr  = 4'b0;
        if (wr_fire) begin
            case (wr_idx)
                REG_LED: begin
                    for (int b = 0; b < 2; b++) begin
                        if (wr_strb[b]) led_d[b*8 +: 8] = wr_data[b*8 +: 8];
                    end
                end
                REG_EDGE: begin
                    if (wr_strb[0]) edge_clr = wr_data[3:0];
                end
                REG_SCRATCH: begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wr_strb[b]) scratch_d[b*8 +: 8] = wr_data[b*8 +: 8];
                    end
                end
                default: ;
            endcase
        end
        edge_d = (edge_q & ~edge_clr) | btn_rise;
    end

    // Register-file state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q     <= '0;
            scratch_q <= '0;
            edge_q    <= '0;
        end else begin
            led_q     <= led_d;
            scratch_q <= scratch_d;
            edge_q    <= edge_d;
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic [1:0]            rd_resp;
    logic                  ar_hs;

    assign ar_hs = axil_if.arvalid && !rvalid_q;

    // Read mux samples current register values, so a same-cycle write is
    // not yet visible.
    always_comb begin
        rd_mux  = '0;
        rd_resp = RESP_OKAY;
        case (araddr_w[4:2])
            REG_ID:      rd_mux = ID_VALUE;
            REG_INPUTS:  rd_mux = {24'b0, btn_s_q, sw_s_q};
            REG_LED:     rd_mux = {16'b0, led_q};
            REG_EDGE:    rd_mux = {28'b0, edge_q};
            REG_SCRATCH: rd_mux = scratch_q;
            default:     rd_resp = RESP_SLVERR;
        endcase
    end

    // R-channel next state: capture on AR, hold until accepted
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
            rresp_d  = rd_resp;
        end else if (rvalid_q && axil_if.rready) begin
            rvalid_d = 1'b0;
        end
    end

    // Read-channel state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign axil_if.awready = awready_w;
    assign axil_if.wready  = wready_w;
    assign axil_if.bvalid  = bvalid_q;
    assign axil_if.bresp   = bresp_q;
    assign axil_if.arready = !rvalid_q;
    assign axil_if.rvalid  = rvalid_q;
    assign axil_if.rdata   = rdata_q;
    assign axil_if.rresp   = rresp_q;
    assign led             = led_q;

    // Address bits outside the decoded word index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{awaddr_w[ADDR_WIDTH-1:5], awaddr_w[1:0],
                                araddr_w[ADDR_WIDTH-1:5], araddr_w[1:0]};

endmodule

// File: tb/tb_axil_gpio_regs.sv
// Directed bench for axil_gpio_regs: register map, strobes, channel
// ordering/backpressure, input sync and edge flags, error responses, reset.
module tb_axil_gpio_regs;

    localparam logic [31:0] ID = 32'h4750_494F;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  sw, btn;
    logic [15:0] led;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] d;
    logic [1:0]  r;

    AXIL_IF #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axil_gpio_regs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_VALUE(ID)) dut (
        .clk(clk), .reset(reset), .axil_if(bus), .sw(sw), .btn(btn), .led(led)
    );

    always #4 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_go, w_go, aw_done, w_done;
        int n;
        @(negedge clk);
        bus.awaddr = addr; bus.awvalid = 1'b1;
        bus.wdata  = data; bus.wstrb = strb; bus.wvalid = 1'b1;
        bus.bready = 1'b1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_go = bus.awvalid && bus.awready;
            w_go  = bus.wvalid && bus.wready;
            @(posedge clk); #1;
            if (aw_go) begin bus.awvalid = 1'b0; aw_done = 1; end
            if (w_go)  begin bus.wvalid  = 1'b0; w_done  = 1; end
            n++;
            if (!(aw_done && w_done)) @(negedge clk);
        end
        if (!(aw_done && w_done)) begin
            check("wr_accept_timeout", 32'd0, 32'd1);
            bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
            resp = 2'bxx;
            return;
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.bvalid && n < 20);
        if (!bus.bvalid) begin
            check("wr_bvalid_timeout", 32'd0, 32'd1);
            bus.bready = 1'b0;
            resp = 2'bxx;
            return;
        end
        resp = bus.bresp;
        @(posedge clk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        @(negedge clk);
        bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b0;
        n = 0;
        while (!bus.arready && n < 20) begin @(negedge clk); n++; end
        if (!bus.arready) begin
            check("rd_ar_timeout", 32'd0, 32'd1);
            bus.arvalid = 1'b0;
            data = 'x; resp = 2'bxx;
            return;
        end
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        @(negedge clk);
        check("rd_latency", bus.rvalid, 1'b1);
        data = bus.rdata; resp = bus.rresp;
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sw = 4'h0; btn = 4'h0;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0;
        bus.arvalid = 1'b0; bus.rready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", bus.awready, 1'b1);
        check("rst_wready",  bus.wready,  1'b1);
        check("rst_arready", bus.arready, 1'b1);
        check("rst_bvalid",  bus.bvalid,  1'b0);
        check("rst_rvalid",  bus.rvalid,  1'b0);
        check("rst_rdata",   bus.rdata,   32'h0);
        check("rst_led",     led,         16'h0);
        reset = 1'b0;

        // ID and LED reset value
        axi_read(32'h00, d, r); check("id", d, ID); check("id_resp", r, 2'b00);
        axi_read(32'h08, d, r); check("led_rd_rst", d, 32'h0);

        // LED byte strobes
        axi_write(32'h08, 32'h0000_A5F3, 4'b0001, r);
        check("led_strb0", led, 16'h00F3);
        axi_write(32'h08, 32'h0000_A5F3, 4'b0011, r);
        check("led_strb01", led, 16'hA5F3); check("led_bresp", r, 2'b00);

        // W three cycles ahead of AW, B held off for four cycles
        @(negedge clk);
        bus.wdata = 32'h0000_1234; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b0;
        @(posedge clk); #1; bus.wvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("wfirst_wready", bus.wready, 1'b0);
        check("wfirst_awready", bus.awready, 1'b1);
        check("wfirst_led_old", led, 16'hA5F3);
        check("wfirst_bvalid", bus.bvalid, 1'b0);
        bus.awaddr = 32'h08; bus.awvalid = 1'b1;
        @(posedge clk); #1; bus.awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bhold_bvalid", bus.bvalid, 1'b1);
            check("bhold_bresp", bus.bresp, 2'b00);
            check("bhold_awready", bus.awready, 1'b0);
            check("bhold_wready", bus.wready, 1'b0);
        end
        check("wfirst_led_new", led, 16'h1234);
        bus.bready = 1'b1;
        @(posedge clk); #1; bus.bready = 1'b0;
        @(negedge clk);
        check("bdone_bvalid", bus.bvalid, 1'b0);
        check("bdone_awready", bus.awready, 1'b1);
        check("bdone_wready", bus.wready, 1'b1);
        check("bdone_led", led, 16'h1234);

        // Synchronised inputs and edge flags
        @(negedge clk); sw = 4'hA; btn = 4'h0;
        repeat (4) @(posedge clk);
        @(negedge clk); btn = 4'h5;
        repeat (4) @(posedge clk);
        axi_read(32'h04, d, r); check("inputs", d, 32'h0000_005A);
        axi_read(32'h0C, d, r); check("edge_set", d, 32'h5);
        axi_write(32'h0C, 32'h1, 4'b0001, r);
        axi_read(32'h0C, d, r); check("edge_w1c", d, 32'h4);
        axi_write(32'h0C, 32'h4, 4'b0000, r);
        axi_read(32'h0C, d, r); check("edge_nostrb", d, 32'h4);

        // New rising edge on bit 3 lands on the same edge as a W1C of bit 3
        @(negedge clk); btn = 4'hD;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.awaddr = 32'h0C; bus.awvalid = 1'b1;
        bus.wdata = 32'h8; bus.wstrb = 4'b0001; bus.wvalid = 1'b1; bus.bready = 1'b1;
        @(posedge clk); #1; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk); check("setclr_bvalid", bus.bvalid, 1'b1);
        @(posedge clk); #1; bus.bready = 1'b0;
        axi_read(32'h0C, d, r); check("setclr_wins", d, 32'hC);

        // Unmapped and read-only accesses
        axi_read(32'h18, d, r); check("unmap_rdata", d, 32'h0); check("unmap_rresp", r, 2'b10);
        axi_write(32'h14, 32'hFFFF_FFFF, 4'hF, r); check("unmap_bresp", r, 2'b10);
        axi_read(32'h08, d, r); check("unmap_led_kept", d, 32'h1234);
        axi_read(32'h10, d, r); check("unmap_scr_kept", d, 32'h0);
        axi_write(32'h00, 32'h0, 4'hF, r); check("ro_bresp", r, 2'b00);
        axi_read(32'h00, d, r); check("ro_id_kept", d, ID);

        // Scratch with strobes
        axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, r);
        axi_read(32'h10, d, r); check("scratch", d, 32'hDEAD_BEEF);
        axi_write(32'h10, 32'h1122_3344, 4'b0100, r);
        axi_read(32'h10, d, r); check("scratch_strb2", d, 32'hDE22_BEEF);

        // Read and write of SCRATCH on the same edge: read sees old value
        @(negedge clk);
        bus.araddr = 32'h10; bus.arvalid = 1'b1; bus.rready = 1'b0;
        bus.awaddr = 32'h10; bus.awvalid = 1'b1;
        bus.wdata = 32'h0; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b1;
        @(posedge clk); #1; bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        check("rw_rvalid", bus.rvalid, 1'b1);
        check("rw_old", bus.rdata, 32'hDE22_BEEF);
        check("rw_bvalid", bus.bvalid, 1'b1);
        bus.rready = 1'b1;
        @(posedge clk); #1; bus.rready = 1'b0; bus.bready = 1'b0;
        axi_read(32'h10, d, r); check("rw_new", d, 32'h0);

        // Reset during a pending read with a held W beat
        axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, r);
        @(negedge clk);
        bus.araddr = 32'h10; bus.arvalid = 1'b1; bus.rready = 1'b0;
        bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(posedge clk); #1; bus.arvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        check("pend_rvalid", bus.rvalid, 1'b1);
        check("pend_wheld", bus.wready, 1'b0);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_rvalid", bus.rvalid, 1'b0);
        check("rst_mid_arready", bus.arready, 1'b1);
        check("rst_mid_wready", bus.wready, 1'b1);
        check("rst_mid_led", led, 16'h0);
        @(negedge clk); reset = 1'b0;
        // Held W must be gone: a lone AW may not complete a write
        @(negedge clk);
        bus.awaddr = 32'h08; bus.awvalid = 1'b1; bus.bready = 1'b1;
        @(posedge clk); #1; bus.awvalid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_no_b", bus.bvalid, 1'b0);
            check("post_rst_led", led, 16'h0);
        end
        bus.wdata = 32'h0000_0042; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(posedge clk); #1; bus.wvalid = 1'b0;
        @(negedge clk);
        check("late_w_bvalid", bus.bvalid, 1'b1);
        check("late_w_led", led, 16'h0042);
        @(posedge clk); #1; bus.bready = 1'b0;
        axi_read(32'h10, d, r); check("post_rst_scratch", d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
